// File: rtl/cpu_store_tracer.sv
// Store-trace monitor for the single-cycle RISC-V core's data-memory write port.
// It buffers every store in a first-word fall-through FIFO, ends the run on a tohost store, and ends it on a cycle watchdog.
module cpu_store_tracer #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0064,
  parameter logic [XLEN-1:0] PASS_DATA   = 32'd1,
  parameter int unsigned     TIMEOUT     = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mem_write,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        write_data,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [XLEN-1:0]        rd_addr,
  output logic [XLEN-1:0]        rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [31:0]            cycle_count
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  logic run_step, is_tohost, store_req, full, push, pop, drop;
  logic finish_tohost, finish_timeout;

  assign run_step  = (state == RUN) && en;
  assign is_tohost = (alu_result == TOHOST_ADDR);
  assign store_req = run_step && mem_write && !is_tohost;
  assign full      = (count == FULL_CNT);
  assign rd_valid  = (count != '0);
  assign pop       = rd_en && rd_valid;
  // A pop frees the slot the same cycle, so a full FIFO can still accept a push.
  assign push      = store_req && (!full || pop);
  assign drop      = store_req && full && !pop;

  always_comb begin
    state_nxt      = state;
    finish_tohost  = 1'b0;
    finish_timeout = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (run_step) begin
          if (mem_write && is_tohost) begin
            finish_tohost = 1'b1;
            state_nxt     = DONE;
          end else if (cycle_count == LAST_CYCLE) begin
            finish_timeout = 1'b1;
            state_nxt      = DONE;
          end
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (run_step)       cycle_count <= cycle_count + 32'd1;
      if (finish_tohost)  pass        <= (write_data == PASS_DATA);
      if (finish_timeout) timeout     <= 1'b1;
      if (drop)           overflow    <= 1'b1;
      if (push)           wr_ptr      <= wr_ptr + PTR_ONE;
      if (pop)            rd_ptr      <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // Buffer contents carry no reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= alu_result;
      data_mem[wr_ptr] <= write_data;
    end
  end

  assign done    = (state == DONE);
  assign rd_addr = addr_mem[rd_ptr];
  assign rd_data = data_mem[rd_ptr];

endmodule

// File: tb/tb_cpu_store_tracer.sv
// Bench for cpu_store_tracer (DEPTH=4, TIMEOUT=10).
// A queue-based reference model is compared every cycle, and directed literal expectations anchor that model.
module tb_cpu_store_tracer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;
  localparam logic [31:0] TOHOST = 32'h0000_0064;
  localparam logic [31:0] PASSV  = 32'd1;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, mem_write = 1'b0, rd_en = 1'b0;
  logic [31:0] alu_result = '0, write_data = '0;
  logic        rd_valid, overflow, done, pass, timeout;
  logic [31:0] rd_addr, rd_data, cycle_count;
  logic [2:0]  count;

  int checks = 0, failures = 0;

  cpu_store_tracer #(.XLEN(32), .DEPTH(DEPTH), .TOHOST_ADDR(TOHOST), .PASS_DATA(PASSV),
                     .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_write(mem_write), .alu_result(alu_result),
    .write_data(write_data), .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .overflow(overflow), .done(done), .pass(pass),
    .timeout(timeout), .cycle_count(cycle_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: run phase, store queue and sticky flags, all stepped on spec rules.
  typedef struct packed {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t        mq[$];
  int          m_phase = 0;  // 0 waiting for enable, 1 running, 2 finished
  int unsigned m_cyc = 0;
  bit          m_ovf = 0, m_pass = 0, m_to = 0;

  always @(posedge clk or negedge rst) begin : model
    bit pop_ok, push_ok;
    if (!rst) begin
      mq.delete();
      m_phase = 0; m_cyc = 0; m_ovf = 0; m_pass = 0; m_to = 0;
    end else begin
      pop_ok  = rd_en && (mq.size() != 0);
      push_ok = 0;
      if (m_phase == 1 && en) begin
        m_cyc++;
        if (mem_write && alu_result == TOHOST) begin
          m_phase = 2; m_pass = (write_data == PASSV); m_to = 0;
        end else begin
          if (mem_write) begin
            if (mq.size() < DEPTH || pop_ok) push_ok = 1;
            else m_ovf = 1;
          end
          if (m_cyc == TIMEOUT) begin m_phase = 2; m_to = 1; m_pass = 0; end
        end
      end else if (m_phase == 0 && en) begin
        m_phase = 1;
      end
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back({alu_result, write_data});
    end
  end

  always @(negedge clk) begin
    chk("cmp_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("cmp_count", 32'(count), mq.size());
    if (mq.size() != 0) begin
      chk("cmp_rd_addr", rd_addr, mq[0].a);
      chk("cmp_rd_data", rd_data, mq[0].d);
    end
    chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
    chk("cmp_done", 32'(done), 32'(m_phase == 2));
    chk("cmp_pass", 32'(pass), 32'(m_pass));
    chk("cmp_timeout", 32'(timeout), 32'(m_to));
    chk("cmp_cycle_count", cycle_count, m_cyc);
  end

  task automatic cyc(input bit e, input bit mw, input logic [31:0] a, input logic [31:0] d,
                     input bit re);
    en = e; mem_write = mw; alu_result = a; write_data = d; rd_en = re;
    @(posedge clk); #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic apply_reset(input bit check_now, input string tag);
    en = 0; mem_write = 0; alu_result = '0; write_data = '0; rd_en = 0;
    rst = 0;
    #1;
    if (check_now) check_all_zero(tag);
    @(posedge clk); #2;
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    apply_reset(1, "por");

    // Two stores, then pops in order, then a pop while empty
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h10, 5, 0);
    cyc(1, 1, 32'h14, 7, 0);
    chk("two_store_count", 32'(count), 2);
    chk("two_store_head_addr", rd_addr, 32'h10);
    chk("two_store_head_data", rd_data, 5);
    cyc(0, 0, 0, 0, 1);
    chk("pop1_addr", rd_addr, 32'h14);
    chk("pop1_data", rd_data, 7);
    chk("pause_cycle_hold", cycle_count, 2);
    cyc(0, 0, 0, 0, 1);
    chk("pop2_empty", 32'(rd_valid), 0);
    cyc(0, 0, 0, 0, 1);
    chk("pop_empty_count", 32'(count), 0);

    // Passing tohost store after three run cycles
    apply_reset(0, "");
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, TOHOST, 1, 0);
    chk("pass_done", 32'(done), 1);
    chk("pass_pass", 32'(pass), 1);
    chk("pass_timeout", 32'(timeout), 0);
    chk("pass_cycle_count", cycle_count, 4);
    chk("pass_no_push", 32'(count), 0);
    cyc(1, 1, 32'h20, 9, 0);
    chk("done_ignores_store", 32'(count), 0);
    chk("done_counter_frozen", cycle_count, 4);

    // Failing tohost value
    apply_reset(0, "");
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, TOHOST, 0, 0);
    chk("fail_done", 32'(done), 1);
    chk("fail_pass", 32'(pass), 0);

    // Watchdog with a pause in the middle
    apply_reset(0, "");
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("to_pause_hold", cycle_count, 5);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    chk("to_not_yet", 32'(done), 0);
    cyc(1, 0, 0, 0, 0);
    chk("to_done", 32'(done), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_pass", 32'(pass), 0);
    chk("to_cycle_count", cycle_count, 10);

    // Tohost store on the final budget cycle wins over the watchdog
    apply_reset(0, "");
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, TOHOST, 1, 0);
    chk("tie_done", 32'(done), 1);
    chk("tie_timeout", 32'(timeout), 0);
    chk("tie_pass", 32'(pass), 1);
    chk("tie_cycle_count", cycle_count, 10);

    // Overflow, push+pop while full, then a reset in the middle of the run
    apply_reset(0, "");
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'h100 + 32'(4 * i), 32'(i + 1), 0);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head_addr", rd_addr, 32'h100);
    chk("ovf_head_data", rd_data, 1);
    cyc(1, 1, 32'h200, 32'hAA, 1);
    chk("full_pp_count", 32'(count), 4);
    chk("full_pp_head", rd_addr, 32'h104);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("tail_addr", rd_addr, 32'h200);
    chk("tail_data", rd_data, 32'hAA);
    cyc(1, 1, 32'h300, 32'hB0, 0);
    cyc(1, 1, 32'h304, 32'hB1, 0);
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_ovf", 32'(overflow), 1);
    chk("pre_rst_cycles", cycle_count, 8);
    apply_reset(1, "midrun_rst");
    cyc(1, 0, 0, 0, 0);
    chk("restart_cycles", cycle_count, 0);
    cyc(1, 1, 32'h30, 32'h33, 0);
    chk("restart_count", 32'(count), 1);
    chk("restart_head", rd_addr, 32'h30);
    chk("restart_cycles1", cycle_count, 1);

    // Pointer wrap via interleaved traffic
    apply_reset(0, "");
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(1, 1, 32'h400 + 32'(4 * k), 32'(k * 11), k >= 3);
    chk("wrap_count", 32'(count), 2);
    chk("wrap_head_addr", rd_addr, 32'h420);
    chk("wrap_head_data", rd_data, 88);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_last_addr", rd_addr, 32'h424);
    chk("wrap_last_data", rd_data, 99);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_empty", 32'(rd_valid), 0);
    chk("wrap_empty_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_store_tracer.md
# cpu_store_tracer

Synthesizable store-trace and run-completion monitor attached to the data-memory write port of the single-cycle RISC-V `cpu`. It captures every store (address, data) into a parametrised FIFO for readout and detects program completion through a store to a configurable "tohost" address. A cycle watchdog ends runs that never complete. It replaces the fixed-length, print-only store monitoring of the CPU bench with a reusable block that supports pass/fail, timeout, buffering and overflow reporting.

## Interface
- `XLEN`, 32, width of address and data
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `TOHOST_ADDR`, 32'h0000_0064, store address that signals end of run
- `PASS_DATA`, 1, tohost data value meaning pass
- `TIMEOUT`, 1000, RUN-state cycle budget; ≥1

- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `en`  input  1  monitor enable
- `mem_write`  input  1  CPU MemWrite
- `alu_result`  input  XLEN  store address (CPU ALUResult)
- `write_data`  input  XLEN  store data (CPU WriteData)
- `rd_en`  input  1  pop head entry
- `rd_valid`  output  1  FIFO non-empty
- `rd_addr`  output  XLEN  head entry address
- `rd_data`  output  XLEN  head entry data
- `count`  output  $clog2(DEPTH)+1  current occupancy
- `overflow`  output  1  sticky: a store was dropped
- `done`  output  1  run finished (terminal)
- `pass`  output  1  valid when done: tohost data == PASS_DATA
- `timeout`  output  1  run ended by watchdog
- `cycle_count`  output  32  RUN cycles elapsed

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE → RUN when `en`=1. No capture in IDLE.
- RUN, `en`=1: `cycle_count` increments each cycle. `en`=0: pause; no capture, counter holds, state stays RUN.
- RUN, `en`=1, `mem_write`=1, `alu_result`≠TOHOST_ADDR: push {alu_result, write_data}.
- RUN, `en`=1, `mem_write`=1, `alu_result`==TOHOST_ADDR: → DONE, `done`=1, `pass`=(write_data==PASS_DATA), `timeout`=0. The tohost store is not pushed.
- RUN, `en`=1, `cycle_count`==TIMEOUT-1 with no tohost store: → DONE, `done`=1, `timeout`=1, `pass`=0.
- Tohost store and timeout on the same cycle: tohost wins (`timeout`=0).
- DONE is terminal until reset. Stores ignored, counter frozen. FIFO remains poppable.
- FIFO: circular buffer, pointers wrap modulo DEPTH.
  - `rd_addr`/`rd_data` show the head combinationally (first-word fall-through). Undefined when `rd_valid`=0.
  - Pop on `rd_en`&&`rd_valid`. `rd_en` when empty is ignored.
  - Push when full without a same-cycle pop: entry dropped, `overflow` set (sticky until reset), count unchanged.
  - Push and pop in the same cycle when full: both occur, count stays DEPTH, no overflow.
  - Push and pop in the same cycle when empty: push only. A pop of a non-existent head is ignored.
- Reset (asynchronous, any time, including mid-run): state IDLE. Outputs `rd_valid`, `count`, `overflow`, `done`, `pass`, `timeout`, `cycle_count` all go to 0. Pointers go to 0. FIFO contents are don't-care.

## Timing
- All state updates occur on the rising edge of `clk`; reset acts immediately, asynchronously.
- Capture latency 1: store sampled at edge N → `rd_valid`/`count` updated after edge N.
- `done`/`pass`/`timeout` are registered and assert after the edge that sampled the tohost store or the final budget cycle.
- `cycle_count` equals the number of RUN&`en` edges seen; it reads TIMEOUT when `timeout` asserts.
- No combinational path from `mem_write`/`alu_result`/`write_data` to any output.

## Test plan
- Reset, `en`=1, stores (0x10,5),(0x14,7) → `count`=2; pops return 0x10/5 then 0x14/7; then `rd_valid`=0.
- Store (0x64,1) after 3 RUN cycles → `done`=1, `pass`=1, `timeout`=0, `cycle_count`=4, no FIFO entry added; later stores ignored.
- Store (0x64,0) → `done`=1, `pass`=0. With TIMEOUT=10 and no tohost store → `done`=1, `timeout`=1, `cycle_count`=10. Tohost store on cycle 10 → `timeout`=0.
- DEPTH=4: 5 stores without pops → `count`=4, `overflow`=1, head still the first store; then push+pop on the same cycle while full → `count`=4, the new entry lands at the tail.
- Drive 3×DEPTH interleaved pushes/pops to force pointer wrap → data order preserved; `rd_en` while empty → no change.
- Assert `rst`=0 mid-run with `count`=3 and `overflow`=1 → all outputs 0 immediately, without a clock edge; after release, `en`=1 restarts the run from IDLE.
